// File: rtl/regfile_sched_if.sv
// Bundle of issue, writeback, register-file write port and status signals around regfile_sched.
// The scheduler takes the slave side; decode, execution units and register file take the master side.
interface regfile_sched_if;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic        issue_writes_rd;
    logic        issue_ready;

    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;

    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        wb_err;

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
        output issue_ready,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        output alu_wb_ready,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        output mem_wb_ready,
        output rf_we, rf_waddr, rf_wdata, busy, wb_err
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
        input  issue_ready,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  alu_wb_ready,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  mem_wb_ready,
        input  rf_we, rf_waddr, rf_wdata, busy, wb_err
    );
endinterface

// File: rtl/regfile_sched.sv
// Register scoreboard with RAW/WAW issue interlock and a round-robin ALU/MEM arbiter
// driving a registered single write port into the integer register file.
module regfile_sched #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    regfile_sched_if.slave   bus
);

    typedef enum logic { SRC_ALU = 1'b0, SRC_MEM = 1'b1 } src_t;

    logic [31:0] busy_q;
    logic [31:0] busy_next;
    src_t        last_grant;
    logic        alu_gnt;
    logic        mem_gnt;
    logic        any_gnt;
    logic [4:0]  gnt_rd;
    logic [31:0] gnt_data;
    logic        issue_fire;
    logic        raw_hazard;
    logic        waw_hazard;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        wb_err_q;

    assign raw_hazard = (bus.issue_uses_rs1 && busy_q[bus.issue_rs1]) ||
                        (bus.issue_uses_rs2 && busy_q[bus.issue_rs2]);
    assign waw_hazard = bus.issue_writes_rd && busy_q[bus.issue_rd];
    assign bus.issue_ready = !rst && !raw_hazard && !waw_hazard;
    assign issue_fire = bus.issue_valid && bus.issue_ready;

    // On a conflict the source that did not win last time gets the port.
    assign alu_gnt = !rst && bus.alu_wb_valid && (!bus.mem_wb_valid || last_grant == SRC_MEM);
    assign mem_gnt = !rst && bus.mem_wb_valid && (!bus.alu_wb_valid || last_grant == SRC_ALU);
    assign any_gnt = alu_gnt || mem_gnt;
    assign gnt_rd   = mem_gnt ? bus.mem_wb_rd   : bus.alu_wb_rd;
    assign gnt_data = mem_gnt ? bus.mem_wb_data : bus.alu_wb_data;

    assign bus.alu_wb_ready = alu_gnt;
    assign bus.mem_wb_ready = mem_gnt;

    always_comb begin
        busy_next = busy_q;
        if (rf_we_q) begin
            busy_next[rf_waddr_q] = 1'b0;
        end
        if (issue_fire && bus.issue_writes_rd) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            last_grant <= FIRST_PRIO ? SRC_ALU : SRC_MEM;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q <= busy_next;
            if (any_gnt) begin
                last_grant <= mem_gnt ? SRC_MEM : SRC_ALU;
                rf_we_q    <= (gnt_rd != 5'd0);
                rf_waddr_q <= gnt_rd;
                rf_wdata_q <= gnt_data;
                if (gnt_rd != 5'd0 && !busy_q[gnt_rd]) begin
                    wb_err_q <= 1'b1;
                end
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy     = busy_q;
    assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_sched.sv
// Directed bench for regfile_sched: reset, RAW/WAW interlock, round-robin conflict,
// x0 handling, sticky error flag and mid-operation reset.
module tb_regfile_sched;

    logic clk;
    logic rst;
    int   checks_total;
    int   checks_passed;

    regfile_sched_if bus ();

    regfile_sched #(.FIRST_PRIO(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2, input logic wr);
        bus.issue_valid     = iv;
        bus.issue_rs1       = rs1;
        bus.issue_rs2       = rs2;
        bus.issue_rd        = rd;
        bus.issue_uses_rs1  = u1;
        bus.issue_uses_rs2  = u2;
        bus.issue_writes_rd = wr;
        #1;
    endtask

    task automatic setWb(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.alu_wb_valid = av;
        bus.alu_wb_rd    = ard;
        bus.alu_wb_data  = ad;
        bus.mem_wb_valid = mv;
        bus.mem_wb_rd    = mrd;
        bus.mem_wb_data  = md;
        #1;
    endtask

    logic [4:0] exp_waddr [4];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        exp_waddr[0] = 5'd1; exp_waddr[1] = 5'd2; exp_waddr[2] = 5'd1; exp_waddr[3] = 5'd2;

        // Reset with every valid held high: nothing may be granted or issued.
        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1);
        setWb(1'b1, 5'd8, 32'h11, 1'b1, 5'd9, 32'h22);
        tick();
        tick();
        checkOutput("rst_busy", bus.busy, 32'h0);
        checkOutput("rst_rf_we", {31'b0, bus.rf_we}, 32'h0);
        checkOutput("rst_wb_err", {31'b0, bus.wb_err}, 32'h0);
        checkOutput("rst_alu_ready", {31'b0, bus.alu_wb_ready}, 32'h0);
        checkOutput("rst_mem_ready", {31'b0, bus.mem_wb_ready}, 32'h0);
        checkOutput("rst_issue_ready", {31'b0, bus.issue_ready}, 32'h0);
        rst = 1'b0;
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 5'd5, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1);
        checkOutput("post_rst_issue_ready", {31'b0, bus.issue_ready}, 32'h1);

        // RAW interlock on x5.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("raw_busy5", bus.busy, 32'h0000_0020);
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        setWb(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        checkOutput("raw_stall", {31'b0, bus.issue_ready}, 32'h0);
        checkOutput("raw_alu_gnt", {31'b0, bus.alu_wb_ready}, 32'h1);
        tick();
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("raw_rf_we", {31'b0, bus.rf_we}, 32'h1);
        checkOutput("raw_rf_waddr", {27'b0, bus.rf_waddr}, 32'd5);
        checkOutput("raw_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        checkOutput("raw_still_stall", {31'b0, bus.issue_ready}, 32'h0);
        tick();
        checkOutput("raw_released", {31'b0, bus.issue_ready}, 32'h1);
        checkOutput("raw_busy_clear", bus.busy, 32'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // WAW interlock on x7, with a same-cycle set of x10 during the clear of x7.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("waw_busy7", bus.busy, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        setWb(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_1234);
        checkOutput("waw_stall", {31'b0, bus.issue_ready}, 32'h0);
        checkOutput("waw_mem_gnt", {31'b0, bus.mem_wb_ready}, 32'h1);
        tick();
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("waw_rf_waddr", {27'b0, bus.rf_waddr}, 32'd7);
        checkOutput("waw_rf_wdata", bus.rf_wdata, 32'h0000_1234);
        checkOutput("waw_still_stall", {31'b0, bus.issue_ready}, 32'h0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("set_clear_same_cycle", bus.busy, 32'h0000_0400);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        checkOutput("waw_released", {31'b0, bus.issue_ready}, 32'h1);

        // Fresh reset, then sustained ALU/MEM conflict alternates starting with ALU.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setWb(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("conf_alu_gnt%0d", i), {31'b0, bus.alu_wb_ready}, {31'b0, (i % 2) == 0});
            checkOutput($sformatf("conf_mem_gnt%0d", i), {31'b0, bus.mem_wb_ready}, {31'b0, (i % 2) == 1});
            tick();
            checkOutput($sformatf("conf_waddr%0d", i), {27'b0, bus.rf_waddr}, {27'b0, exp_waddr[i]});
            checkOutput($sformatf("conf_wdata%0d", i), bus.rf_wdata,
                        ((i % 2) == 0) ? 32'h0000_00A1 : 32'h0000_00B2);
        end
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("idle_rf_we", {31'b0, bus.rf_we}, 32'h0);
        checkOutput("idle_waddr_hold", {27'b0, bus.rf_waddr}, 32'd2);

        // x0 destination: no scoreboard bit, granted but not written, no error.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_clears_err", {31'b0, bus.wb_err}, 32'h0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("x0_busy", bus.busy, 32'h0);
        setWb(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_5555);
        checkOutput("x0_mem_gnt", {31'b0, bus.mem_wb_ready}, 32'h1);
        tick();
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("x0_rf_we", {31'b0, bus.rf_we}, 32'h0);
        checkOutput("x0_wb_err", {31'b0, bus.wb_err}, 32'h0);

        // Writeback to non-busy x9 is performed and flags a sticky error.
        setWb(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0);
        checkOutput("err_alu_gnt", {31'b0, bus.alu_wb_ready}, 32'h1);
        tick();
        setWb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("err_rf_we", {31'b0, bus.rf_we}, 32'h1);
        checkOutput("err_rf_waddr", {27'b0, bus.rf_waddr}, 32'd9);
        checkOutput("err_rf_wdata", bus.rf_wdata, 32'h0000_0099);
        checkOutput("err_set", {31'b0, bus.wb_err}, 32'h1);
        tick();
        tick();
        checkOutput("err_sticky", {31'b0, bus.wb_err}, 32'h1);

        // Mid-operation reset discards pending busy bits and the error flag.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_busy34", bus.busy, 32'h0000_0018);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_busy", bus.busy, 32'h0);
        checkOutput("mid_rst_err", {31'b0, bus.wb_err}, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("mid_after_busy", bus.busy, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
